// File: rtl/robot_plant_pkg.sv
// robot_plant_pkg: shared definitions for the robot cell plant model.
// Holds the controller command bit positions (yk lives at index k-1)
// and the state encoding used by the sensor pulse generators.
package robot_plant_pkg;

  localparam int CMD_MOVE   = 33;
  localparam int CMD_CLAMP  = 11;
  localparam int CMD_GRIP   = 27;
  localparam int CMD_LOAD   = 12;
  localparam int CMD_UNLOAD = 1;
  localparam int CMD_COUNT  = 6;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_DELAY = 2'd1,
    PS_HOLD  = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/plant_pulse_gen.sv
// plant_pulse_gen: delayed fixed-width sensor pulse.
// A trigger seen in IDLE waits DLY edges, then holds pulse high for HOLD edges.
// Triggers arriving while the generator is busy are ignored; busy lets the
// parent flag them. HOLD=0 behaves as HOLD=1, DLY=0 behaves as DLY=1.
module plant_pulse_gen
  import robot_plant_pkg::*;
#(
  parameter int DLY   = 3,
  parameter int HOLD  = 2,
  parameter int TMR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic busy,
  output logic pulse
);

  localparam logic [TMR_W-1:0] DLY_V  = TMR_W'(DLY);
  localparam logic [TMR_W-1:0] HOLD_V = TMR_W'((HOLD == 0) ? 1 : HOLD);
  localparam logic [TMR_W-1:0] ONE    = TMR_W'(1);

  pulse_state_t     state;
  logic [TMR_W-1:0] cnt;

  // Pulse FSM: count down the delay, raise pulse, count down the hold, drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PS_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      case (state)
        PS_IDLE: begin
          if (trig) begin
            state <= PS_DELAY;
            cnt   <= DLY_V;
          end
        end
        PS_DELAY: begin
          if (cnt <= ONE) begin
            state <= PS_HOLD;
            pulse <= 1'b1;
            cnt   <= HOLD_V;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        PS_HOLD: begin
          if (cnt <= ONE) begin
            state <= PS_IDLE;
            pulse <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= PS_IDLE;
          pulse <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != PS_IDLE);

endmodule

// File: rtl/robot_plant_model.sv
// robot_plant_model: cycle-based environment of the robot cell.
// Turns controller commands y1..y43 into registered sensor returns x1..x5:
// motion done, gripper/clamp pulses, part present and batch complete.
// Optional macro PLANT_CHECK_EN adds a sticky protocol error output err.
module robot_plant_model
  import robot_plant_pkg::*;
#(
  parameter int TMR_W    = 8,
  parameter int MOVE_DLY = 4,
  parameter int X3_DLY   = 3,
  parameter int X3_HOLD  = 2,
  parameter int X2_DLY   = 3,
  parameter int X2_HOLD  = 2,
  parameter int PART_DLY = 5,
  parameter int BATCH_N  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [42:0] y,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        x4,
  output logic        x5
`ifdef PLANT_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam logic [TMR_W-1:0] MOVE_V  = TMR_W'((MOVE_DLY == 0) ? 1 : MOVE_DLY);
  localparam logic [TMR_W-1:0] PART_V  = TMR_W'(PART_DLY);
  localparam logic [TMR_W-1:0] T_ONE   = TMR_W'(1);
  localparam int               CNT_W   = (BATCH_N < 1) ? 1 : $clog2(BATCH_N + 1);
  localparam logic [CNT_W-1:0] BATCH_V = CNT_W'(BATCH_N);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  logic cmd_move, cmd_clamp, cmd_grip, cmd_load, cmd_unload, cmd_count;

  assign cmd_move   = y[CMD_MOVE];
  assign cmd_clamp  = y[CMD_CLAMP];
  assign cmd_grip   = y[CMD_GRIP];
  assign cmd_load   = y[CMD_LOAD];
  assign cmd_unload = y[CMD_UNLOAD];
  assign cmd_count  = y[CMD_COUNT];

  logic [TMR_W-1:0] mtmr;
  logic [TMR_W-1:0] ptmr;
  logic             parm;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             x2_busy, x3_busy;

  // Move: a command drops x1 and (re)starts the countdown; x1 rises on the 1->0 step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtmr <= '0;
      x1   <= 1'b0;
    end else if (cmd_move) begin
      mtmr <= MOVE_V;
      x1   <= 1'b0;
    end else if (mtmr != '0) begin
      mtmr <= mtmr - T_ONE;
      if (mtmr == T_ONE) begin
        x1 <= 1'b1;
      end
    end
  end

  plant_pulse_gen #(
    .DLY  (X3_DLY),
    .HOLD (X3_HOLD),
    .TMR_W(TMR_W)
  ) u_clamp_pulse (
    .clk  (clk),
    .rst  (rst),
    .trig (cmd_clamp),
    .busy (x3_busy),
    .pulse(x3)
  );

  plant_pulse_gen #(
    .DLY  (X2_DLY),
    .HOLD (X2_HOLD),
    .TMR_W(TMR_W)
  ) u_grip_pulse (
    .clk  (clk),
    .rst  (rst),
    .trig (cmd_grip),
    .busy (x2_busy),
    .pulse(x2)
  );

  // Part arrival: unload restarts the arrival countdown, load takes the part and idles the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptmr <= PART_V;
      parm <= 1'b1;
      x4   <= 1'b0;
    end else if (cmd_unload) begin
      ptmr <= PART_V;
      parm <= 1'b1;
      x4   <= 1'b0;
    end else if (cmd_load) begin
      parm <= 1'b0;
      x4   <= 1'b0;
    end else if (parm) begin
      if (ptmr <= T_ONE) begin
        ptmr <= '0;
        parm <= 1'b0;
        x4   <= 1'b1;
      end else begin
        ptmr <= ptmr - T_ONE;
      end
    end
  end

  // Batch count: a full-batch unload clears the count and takes priority over a count pulse.
  always_comb begin
    cnt_nxt = cnt;
    if (cmd_unload && x5) begin
      cnt_nxt = '0;
    end else if (cmd_count && (cnt != BATCH_V)) begin
      cnt_nxt = cnt + C_ONE;
    end
  end

  // Batch register: x5 is registered from the next count so it tracks cnt exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      x5  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      x5  <= (cnt_nxt == BATCH_V);
    end
  end

`ifdef PLANT_CHECK_EN
  // Protocol checker: latch any command the plant cannot honour in its current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((cmd_move  && (mtmr != '0)) ||
                 (cmd_clamp && x3_busy)      ||
                 (cmd_grip  && x2_busy)      ||
                 (cmd_load  && !x4)          ||
                 (cmd_count && (cnt == BATCH_V))) begin
      err <= 1'b1;
    end
  end
`endif

  // Command bits with no plant behaviour, and the busy flags in builds without
  // the checker, are folded here so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{y, x2_busy, x3_busy};

endmodule

// File: tb/tb_robot_plant_model.sv
// tb_robot_plant_model: scoreboard bench for robot_plant_model.
// Commands are driven on negedge; a timestamp-based model predicts every
// output after each posedge and queues it, and the queue is drained and
// compared shortly after that edge.
module tb_robot_plant_model;

  localparam int MOVE_DLY = 4;
  localparam int X3_DLY   = 3;
  localparam int X3_HOLD  = 2;
  localparam int X2_DLY   = 3;
  localparam int X2_HOLD  = 2;
  localparam int PART_DLY = 5;
  localparam int BATCH_N  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [42:0] y;
  logic        x1, x2, x3, x4, x5;
`ifdef PLANT_CHECK_EN
  logic        err;
`endif

  robot_plant_model #(
    .TMR_W   (8),
    .MOVE_DLY(MOVE_DLY),
    .X3_DLY  (X3_DLY),
    .X3_HOLD (X3_HOLD),
    .X2_DLY  (X2_DLY),
    .X2_HOLD (X2_HOLD),
    .PART_DLY(PART_DLY),
    .BATCH_N (BATCH_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .y  (y),
    .x1 (x1),
    .x2 (x2),
    .x3 (x3),
    .x4 (x4),
    .x5 (x5)
`ifdef PLANT_CHECK_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic x1;
    logic x2;
    logic x3;
    logic x4;
    logic x5;
    logic err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Model state: edges since reset release and the edge at which each channel was started.
  int   e;
  bit   move_seen;
  int   move_at;
  bit   s3_v;
  int   s3;
  bit   s2_v;
  int   s2;
  bit   part_armed;
  int   part_at;
  int   m_cnt;
  bit   m_err;
  bit   m_x4;

  task automatic checkOutput(input string tag, input logic act, input logic expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("[TB] FAIL %s at edge %0d: got %b, want %b", tag, e, act, expv);
    end
  endtask

  task automatic model_reset();
    exp_t ex;
    e          = 0;
    move_seen  = 1'b0;
    move_at    = 0;
    s3_v       = 1'b0;
    s3         = 0;
    s2_v       = 1'b0;
    s2         = 0;
    part_armed = 1'b1;
    part_at    = 0;
    m_cnt      = 0;
    m_err      = 1'b0;
    m_x4       = 1'b0;
    ex         = '0;
    sb_q.push_back(ex);
  endtask

  task automatic model_edge(input logic [42:0] yv);
    exp_t ex;
    bit   mv_busy, c_busy, g_busy;
    e++;
    mv_busy = move_seen && (e <= move_at + MOVE_DLY);
    c_busy  = s3_v && (e <= s3 + X3_DLY + X3_HOLD);
    g_busy  = s2_v && (e <= s2 + X2_DLY + X2_HOLD);
    if ((yv[33] && mv_busy) || (yv[11] && c_busy) || (yv[27] && g_busy) ||
        (yv[12] && !m_x4) || (yv[6] && (m_cnt == BATCH_N)))
      m_err = 1'b1;
    if (yv[33]) begin
      move_seen = 1'b1;
      move_at   = e;
    end
    if (yv[11] && !c_busy) begin
      s3_v = 1'b1;
      s3   = e;
    end
    if (yv[27] && !g_busy) begin
      s2_v = 1'b1;
      s2   = e;
    end
    if (yv[1]) begin
      part_armed = 1'b1;
      part_at    = e;
    end else if (yv[12]) begin
      part_armed = 1'b0;
    end
    if (yv[1] && (m_cnt == BATCH_N)) m_cnt = 0;
    else if (yv[6] && (m_cnt < BATCH_N)) m_cnt++;
    m_x4   = part_armed && (e >= part_at + PART_DLY);
    ex.x1  = move_seen && (e >= move_at + MOVE_DLY);
    ex.x3  = s3_v && (e >= s3 + X3_DLY) && (e < s3 + X3_DLY + X3_HOLD);
    ex.x2  = s2_v && (e >= s2 + X2_DLY) && (e < s2 + X2_DLY + X2_HOLD);
    ex.x4  = m_x4;
    ex.x5  = (m_cnt == BATCH_N);
    ex.err = m_err;
    sb_q.push_back(ex);
  endtask

  task automatic compare_front();
    exp_t ex;
    ex = sb_q.pop_front();
    checkOutput("x1", x1, ex.x1);
    checkOutput("x2", x2, ex.x2);
    checkOutput("x3", x3, ex.x3);
    checkOutput("x4", x4, ex.x4);
    checkOutput("x5", x5, ex.x5);
`ifdef PLANT_CHECK_EN
    checkOutput("err", err, ex.err);
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic [42:0] yv);
    @(negedge clk);
    rst = r;
    y   = yv;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(yv);
    #1;
    compare_front();
  endtask

  // Command schedule, indexed by edge number after reset release.
  function automatic logic [42:0] cmd_for(input int ed);
    logic [42:0] v;
    v = '0;
    case (ed)
      10, 12:         v[33] = 1'b1;
      20, 22:         v[11] = 1'b1;
      30, 32, 34:     v[6]  = 1'b1;
      40:             v[1]  = 1'b1;
      50:             begin v[1] = 1'b1; v[12] = 1'b1; end
      60:             v[27] = 1'b1;
      70:             v[12] = 1'b1;
      72:             v[1]  = 1'b1;
      80, 81, 82, 84: v[6]  = 1'b1;
      86:             begin v[6] = 1'b1; v[1] = 1'b1; end
      90:             begin v[33] = 1'b1; v[11] = 1'b1; end
      92:             begin v[0] = 1'b1; v[20] = 1'b1; v[42] = 1'b1; end
      100:            v[27] = 1'b1;
      default:        v = '0;
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    y   = '0;
    e   = 0;
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
    for (int i = 1; i <= 103; i++) begin
      applyStimulus(1'b0, cmd_for(i));
    end
    // Reset lands while the gripper pulse is high.
    applyStimulus(1'b1, '0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, '0);
    end
    checkOutput("sb_drain", logic'(sb_q.size() == 0), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
